// File: rtl/sha_round_ctrl_pkg.sv
//==============================================================================
// Module      : sha_round_ctrl_pkg
// Description : Shared types and defaults for the SHA-256 round sequencer:
//               state encoding, default geometry and the Moore output decode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sha_round_ctrl_pkg;

  // Default compression geometry for one SHA-256 block
  localparam int ROUNDS_DEF   = 64;
  localparam int IDX_W_DEF    = 6;
  localparam int WAIT_MAX_DEF = 4;

  // Sequencer states, 3-bit encoding shared with the datapath debug taps
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_HASH  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CHAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Bundle of single-bit control outputs, registered as one word
  typedef struct packed {
    logic ready;
    logic iv_sel;
    logic load_en;
    logic round_en;
    logic hash_en;
    logic chain_en;
    logic done;
  } ctrl_out_t;

  // Moore decode: every strobe is a pure function of the state it belongs to.
  // iv_sel is only meaningful while the working variables are loaded.
  function automatic ctrl_out_t decode_outputs(input state_e st, input logic first);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_IDLE:  o.ready    = 1'b1;
      ST_LOAD:  begin
                  o.load_en = 1'b1;
                  o.iv_sel  = first;
                end
      ST_ROUND: o.round_en = 1'b1;
      ST_HASH:  o.hash_en  = 1'b1;
      ST_CHAIN: o.chain_en = 1'b1;
      ST_DONE:  o.done     = 1'b1;
      default:  o          = '0;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha_round_ctrl.sv
//==============================================================================
// Module      : sha_round_ctrl
// Description : Sequencing controller for one SHA-256 compression pass.
//               Handshakes a block start, loads a..h, issues ROUNDS round
//               enables with their index, strobes the H update, waits for the
//               sha_hash completion pulse and then either flags the final
//               digest or chains it as H_i for the next block.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sha_round_ctrl
  import sha_round_ctrl_pkg::*;
#(
  parameter int ROUNDS   = ROUNDS_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             first_block,
  input  logic             last_block,
  input  logic             hash_done,
  output logic             ready,
  output logic             iv_sel,
  output logic             load_en,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             hash_en,
  output logic             chain_en,
  output logic             done,
  output logic             err
);

  // Wait counter must be able to hold WAIT_MAX-1
  localparam int               WCNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  // A round index too narrow for ROUNDS would silently alias K/W selects
  if (2 ** IDX_W < ROUNDS) begin : g_idx_w_check
    $error("sha_round_ctrl: IDX_W too small for ROUNDS");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [WCNT_W-1:0] wcnt_q,  wcnt_d;
  logic              first_q, first_d;
  logic              last_q,  last_d;
  logic              err_q,   err_d;
  ctrl_out_t         out_q,   out_d;

  // Next-state, counter and flag update; outputs pre-decoded from the next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          first_d = first_block;
          last_d  = last_block;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_ROUND;
        idx_d   = '0;
      end
      ST_ROUND: begin
        // Index saturates at the last round; the exit happens on that same cycle
        if (idx_q == LAST_IDX) begin
          state_d = ST_HASH;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_HASH: begin
        state_d = ST_WAIT;
        wcnt_d  = '0;
      end
      ST_WAIT: begin
        if (hash_done) begin
          state_d = last_q ? ST_DONE : ST_CHAIN;
        end else if (wcnt_q == WAIT_LAST) begin
          // WAIT_MAX cycles without completion: give up and flag it
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_CHAIN: state_d = ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    out_d = decode_outputs(state_d, first_d);
  end

  // State, counters, flags and registered outputs; reset dominates start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= decode_outputs(ST_IDLE, 1'b0);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign ready     = out_q.ready;
  assign iv_sel    = out_q.iv_sel;
  assign load_en   = out_q.load_en;
  assign round_en  = out_q.round_en;
  assign hash_en   = out_q.hash_en;
  assign chain_en  = out_q.chain_en;
  assign done      = out_q.done;
  assign round_idx = idx_q;
  assign err       = err_q;

endmodule

`default_nettype wire
